wb_stage: RTL and testbench

//   Write-back end of the EX stage interface. Registers the EX results (sum, extensor, rd, control)
//   and selects the write-back value. Commits it to an 8-entry register file. Returns ex_wb_rd and

---
 rtl/wb_stage.sv | 90 +++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register for EX results, 8-entry register file with
// single commit port, forwarding outputs to EX and bypassed read ports for ID.
module wb_stage #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              signaltoReg_in,
    input  logic              writeReg_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] sum_in,
    input  logic [DATA_W-1:0] extensor_in,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [ADDR_W-1:0] ex_wb_rd,
    output logic [DATA_W-1:0] forward_data,
    output logic              wb_valid
);

    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        we_d   = we_q;
        rd_d   = rd_q;
        data_d = data_q;
        regs_d = regs_q;

        // The held entry commits on the first non-stalled edge, while the next one loads.
        if (we_q && !stall) begin
            regs_d[rd_q] = data_q;
        end

        if (!stall) begin
            rd_d   = rd_in;
            data_d = signaltoReg_in ? extensor_in : sum_in;
            we_d   = valid_in & writeReg_in & (rd_in != '0);
        end

        // Flush kills the entry even while stalled, dropping any held write.
        if (flush) begin
            we_d = 1'b0;
        end
    end

    // NOTE: the register file is reset along with the pipeline register so every
    // architectural register reads 0 after reset; use <= only in sequential blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (we_q && rs1_addr == rd_q) ? data_q : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (we_q && rs2_addr == rd_q) ? data_q : regs_q[rs2_addr];
        end
    end

    assign wb_valid     = we_q;
    assign ex_wb_rd     = we_q ? rd_q : '0;
    assign forward_data = we_q ? data_q : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, flush, valid_in, signaltoReg_in, writeReg_in;
    logic [2:0] rd_in, rs1_addr, rs2_addr;
    logic [7:0] sum_in, extensor_in;
    logic [7:0] rs1_data, rs2_data, forward_data;
    logic [2:0] ex_wb_rd;
    logic       wb_valid;

    int n_checks = 0;
    int n_errors = 0;
    bit compare_en = 1'b0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .valid_in       (valid_in),
        .signaltoReg_in (signaltoReg_in),
        .writeReg_in    (writeReg_in),
        .rd_in          (rd_in),
        .sum_in         (sum_in),
        .extensor_in    (extensor_in),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .ex_wb_rd       (ex_wb_rd),
        .forward_data   (forward_data),
        .wb_valid       (wb_valid)
    );

    // Behavioural model: architectural registers plus one pending write.
    typedef struct {
        bit       v;
        bit [2:0] rd;
        bit [7:0] d;
    } pend_t;

    bit [7:0] m_regs [8];
    pend_t    pend;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        pend = '{v: 1'b0, rd: 3'd0, d: 8'h00};
    endtask

    function automatic bit [7:0] m_read(input bit [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (pend.v && pend.rd == a) return pend.d;
        return m_regs[a];
    endfunction

    // Apply one rising edge to the model using the inputs as they stood at the edge.
    task automatic model_edge();
        if (pend.v && !stall) m_regs[pend.rd] = pend.d;
        if (flush) begin
            pend.v = 1'b0;
        end else if (!stall) begin
            pend.v  = valid_in && writeReg_in && (rd_in != 3'd0);
            pend.rd = rd_in;
            pend.d  = signaltoReg_in ? extensor_in : sum_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ex(input bit v, input bit wr, input bit sel, input bit [2:0] rd,
                          input bit [7:0] sum, input bit [7:0] ext,
                          input bit stl, input bit fl);
        valid_in       = v;
        writeReg_in    = wr;
        signaltoReg_in = sel;
        rd_in          = rd;
        sum_in         = sum;
        extensor_in    = ext;
        stall          = stl;
        flush          = fl;
    endtask

    task automatic idle(input bit stl);
        set_ex(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, stl, 1'b0);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int a = 1; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'(8 - a);
            #1;
            check({tag, "_rs1"}, rs1_data, 8'h00);
            check({tag, "_rs2"}, rs2_data, 8'h00);
        end
    endtask

    // Single compare process: DUT outputs against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (compare_en) begin
            check("cmp_rs1", rs1_data, m_read(rs1_addr));
            check("cmp_rs2", rs2_data, m_read(rs2_addr));
            check("cmp_rd", {5'd0, ex_wb_rd}, {5'd0, pend.v ? pend.rd : 3'd0});
            check("cmp_fwd", forward_data, pend.v ? pend.d : 8'h00);
            check("cmp_valid", {7'd0, wb_valid}, {7'd0, pend.v});
        end
    end

    initial begin
        rst_n    = 1'b0;
        rs1_addr = 3'd0;
        rs2_addr = 3'd0;
        idle(1'b0);
        model_reset();
        #12;
        rst_n = 1'b1;
        check_regs_zero("reset_regs");
        check("reset_valid", {7'd0, wb_valid}, 8'h00);
        compare_en = 1'b1;

        // Sum write to r3 with bypass, then commit.
        set_ex(1'b1, 1'b1, 1'b0, 3'd3, 8'h2A, 8'h99, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        rs1_addr = 3'd3;
        #1;
        check("sum_rd", {5'd0, ex_wb_rd}, 8'h03);
        check("sum_fwd", forward_data, 8'h2A);
        check("sum_bypass", rs1_data, 8'h2A);
        tick();
        check("sum_commit", rs1_data, 8'h2A);
        check("sum_valid_low", {7'd0, wb_valid}, 8'h00);

        // Immediate write to r5.
        set_ex(1'b1, 1'b1, 1'b1, 3'd5, 8'h10, 8'hFD, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        #1;
        check("imm_fwd", forward_data, 8'hFD);
        tick();
        rs2_addr = 3'd5;
        #1;
        check("imm_commit", rs2_data, 8'hFD);

        // Stalled write to r2 holds for three cycles, then commits once.
        set_ex(1'b1, 1'b1, 1'b0, 3'd2, 8'h11, 8'h00, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd", {5'd0, ex_wb_rd}, 8'h02);
            check("stall_valid", {7'd0, wb_valid}, 8'h01);
        end
        idle(1'b0);
        tick();
        rs1_addr = 3'd2;
        #1;
        check("stall_commit", rs1_data, 8'h11);
        check("stall_valid_low", {7'd0, wb_valid}, 8'h00);

        // Flush to r4, then write to r0.
        set_ex(1'b1, 1'b1, 1'b0, 3'd4, 8'h77, 8'h00, 1'b0, 1'b1);
        tick();
        rs1_addr = 3'd4;
        #1;
        check("flush_valid", {7'd0, wb_valid}, 8'h00);
        check("flush_r4", rs1_data, 8'h00);
        set_ex(1'b1, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
        tick();
        rs1_addr = 3'd0;
        #1;
        check("x0_rd", {5'd0, ex_wb_rd}, 8'h00);
        check("x0_fwd", forward_data, 8'h00);
        check("x0_read", rs1_data, 8'h00);

        // Back-to-back writes to r6.
        set_ex(1'b1, 1'b1, 1'b0, 3'd6, 8'h01, 8'h00, 1'b0, 1'b0);
        tick();
        check("b2b_fwd1", forward_data, 8'h01);
        set_ex(1'b1, 1'b1, 1'b0, 3'd6, 8'h02, 8'h00, 1'b0, 1'b0);
        tick();
        rs1_addr = 3'd6;
        #1;
        check("b2b_fwd2", forward_data, 8'h02);
        check("b2b_bypass", rs1_data, 8'h02);
        idle(1'b0);
        tick();
        check("b2b_final", rs1_data, 8'h02);

        // Async reset mid-cycle with a write pending.
        set_ex(1'b1, 1'b1, 1'b0, 3'd7, 8'h5C, 8'h00, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_rs1", rs1_data, 8'h00);
        check("arst_rd", {5'd0, ex_wb_rd}, 8'h00);
        check("arst_fwd", forward_data, 8'h00);
        check("arst_valid", {7'd0, wb_valid}, 8'h00);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        check_regs_zero("arst_regs");

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            set_ex(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                   1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
            rs1_addr = 3'($urandom);
            rs2_addr = 3'($urandom);
            tick();
        end

        compare_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
